aes_round_key_scheduler: RTL and testbench

- Sequences the AES-256 key-expansion engine and captures its round-key stream into a 15-entry round-key store.
- Serves round-key reads to two requesters, encrypt and decrypt, through a round-robin arbiter.
- Sits between the host key-load interface, the key-expansion engine and the cipher round datapaths.

---
 rtl/aes_round_key_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_aes_round_key_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_scheduler.sv
// rtl/aes_round_key_scheduler.sv - AES-256 round-key sequencer, 15-entry key store and enc/dec read arbiter
// Optional zeroize input is enabled with KEY_ZEROIZE_EN.
module aes_round_key_scheduler #(
    parameter int NUM_ROUNDS = 14,
    parameter int KEY_W      = 256,
    parameter int TIMEOUT    = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef KEY_ZEROIZE_EN
    input  logic             zeroize,
`endif
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    output logic             key_ready,
    output logic             keys_valid,
    output logic             exp_err,
    output logic             exp_start,
    output logic [KEY_W-1:0] exp_key,
    input  logic             exp_valid,
    input  logic [127:0]     exp_subkey,
    input  logic             enc_req,
    input  logic [3:0]       enc_round,
    input  logic             dec_req,
    input  logic [3:0]       dec_round,
    output logic             enc_gnt,
    output logic             dec_gnt,
    output logic             rd_valid,
    output logic             rd_id,
    output logic             rd_err,
    output logic [127:0]     rd_data
);

    localparam int DEPTH = NUM_ROUNDS + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [127:0]       r_store [DEPTH];
    logic [CNT_W-1:0]   r_count;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_rr_ptr;
    logic               r_exp_err;
    logic               r_exp_start;
    logic [KEY_W-1:0]   r_exp_key;
    logic               r_rd_valid;
    logic               r_rd_id;
    logic               r_rd_err;
    logic [127:0]       r_rd_data;

    logic               w_zeroize;
    logic               w_accept;
    logic               w_wr_en;
    logic               w_last_wr;
    logic               w_abort;
    logic               w_arb_en;
    logic               w_enc_gnt;
    logic               w_dec_gnt;
    logic               w_gnt;
    logic [3:0]         w_rd_round;
    logic               w_rd_oob;
    logic [127:0]       w_rd_word;

`ifdef KEY_ZEROIZE_EN
    assign w_zeroize = zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    assign w_accept  = key_load && key_ready && !w_zeroize;
    assign w_wr_en   = (r_state == S_EXPAND) && exp_valid && !w_zeroize
                       && (r_count < CNT_W'(DEPTH));
    assign w_last_wr = w_wr_en && (r_count == CNT_W'(DEPTH - 1));
    // Completing the store on the final allowed cycle beats the timeout.
    assign w_abort   = (r_state == S_EXPAND) && !w_last_wr && !w_zeroize
                       && (r_tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_zeroize) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_accept) w_next_state = S_EXPAND;
                S_EXPAND: begin
                    if (w_last_wr)    w_next_state = S_READY;
                    else if (w_abort) w_next_state = S_IDLE;
                end
                S_READY:  if (w_accept) w_next_state = S_EXPAND;
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        key_ready  = 1'b0;
        keys_valid = 1'b0;
        w_arb_en   = 1'b0;
        case (r_state)
            S_IDLE:  key_ready = 1'b1;
            S_READY: begin
                key_ready  = 1'b1;
                keys_valid = 1'b1;
                w_arb_en   = 1'b1;
            end
            default: ;
        endcase
    end

    // r_rr_ptr = 0 favours encrypt when both request.
    assign w_enc_gnt  = w_arb_en && !w_accept && !w_zeroize && enc_req
                        && (!dec_req || !r_rr_ptr);
    assign w_dec_gnt  = w_arb_en && !w_accept && !w_zeroize && dec_req
                        && (!enc_req || r_rr_ptr);
    assign w_gnt      = w_enc_gnt || w_dec_gnt;
    assign w_rd_round = w_dec_gnt ? dec_round : enc_round;
    assign w_rd_oob   = w_rd_round > 4'(NUM_ROUNDS);
    assign w_rd_word  = w_rd_oob ? '0 : r_store[w_rd_round];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_store[i] <= '0;
            end
            r_count     <= '0;
            r_tmo       <= '0;
            r_rr_ptr    <= 1'b0;
            r_exp_err   <= 1'b0;
            r_exp_start <= 1'b0;
            r_exp_key   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_id     <= 1'b0;
            r_rd_err    <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_exp_start <= w_accept;
            if (w_zeroize) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_store[i] <= '0;
                end
                r_exp_key <= '0;
                r_count   <= '0;
                r_tmo     <= '0;
            end else if (w_accept) begin
                r_exp_key <= key_in;
                r_exp_err <= 1'b0;
                r_count   <= '0;
                r_tmo     <= '0;
            end else if (r_state == S_EXPAND) begin
                r_tmo <= r_tmo + TMO_W'(1);
                if (w_wr_en) begin
                    r_store[r_count] <= exp_subkey;
                    r_count          <= r_count + CNT_W'(1);
                end
                if (w_abort) begin
                    r_exp_err <= 1'b1;
                end
            end

            if (w_enc_gnt) begin
                r_rr_ptr <= 1'b1;
            end else if (w_dec_gnt) begin
                r_rr_ptr <= 1'b0;
            end

            r_rd_valid <= w_gnt;
            r_rd_id    <= w_dec_gnt;
            r_rd_err   <= w_gnt && w_rd_oob;
            r_rd_data  <= w_gnt ? w_rd_word : '0;
        end
    end

    assign exp_err   = r_exp_err;
    assign exp_start = r_exp_start;
    assign exp_key   = r_exp_key;
    assign enc_gnt   = w_enc_gnt;
    assign dec_gnt   = w_dec_gnt;
    assign rd_valid  = r_rd_valid;
    assign rd_id     = r_rd_id;
    assign rd_err    = r_rd_err;
    assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_aes_round_key_scheduler.sv
// tb/tb_aes_round_key_scheduler.sv - directed self-checking bench for aes_round_key_scheduler
// Zeroize checks are compiled in with KEY_ZEROIZE_EN.
module tb_aes_round_key_scheduler;

    logic         clk = 1'b0;
    logic         reset;
`ifdef KEY_ZEROIZE_EN
    logic         zeroize;
`endif
    logic         key_load;
    logic [255:0] key_in;
    logic         key_ready;
    logic         keys_valid;
    logic         exp_err;
    logic         exp_start;
    logic [255:0] exp_key;
    logic         exp_valid;
    logic [127:0] exp_subkey;
    logic         enc_req;
    logic [3:0]   enc_round;
    logic         dec_req;
    logic [3:0]   dec_round;
    logic         enc_gnt;
    logic         dec_gnt;
    logic         rd_valid;
    logic         rd_id;
    logic         rd_err;
    logic [127:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_gnt;
    int n_cyc;

    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K2 = {8{32'hfeedface}};
    localparam logic [255:0] K3 = {8{32'h5a5aa5a5}};

    always #5 clk = ~clk;

    aes_round_key_scheduler dut (
        .clk        (clk),
        .reset      (reset),
`ifdef KEY_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key_load   (key_load),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .exp_err    (exp_err),
        .exp_start  (exp_start),
        .exp_key    (exp_key),
        .exp_valid  (exp_valid),
        .exp_subkey (exp_subkey),
        .enc_req    (enc_req),
        .enc_round  (enc_round),
        .dec_req    (dec_req),
        .dec_round  (dec_round),
        .enc_gnt    (enc_gnt),
        .dec_gnt    (dec_gnt),
        .rd_valid   (rd_valid),
        .rd_id      (rd_id),
        .rd_err     (rd_err),
        .rd_data    (rd_data)
    );

    function automatic logic [127:0] pat(input logic [3:0] n);
        return {32{n}};
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
`ifdef KEY_ZEROIZE_EN
        zeroize    = 1'b0;
`endif
        key_load   = 1'b0;
        key_in     = '0;
        exp_valid  = 1'b0;
        exp_subkey = '0;
        enc_req    = 1'b0;
        enc_round  = '0;
        dec_req    = 1'b0;
        dec_round  = '0;
        tick;
        tick;
        check("rst_key_ready", key_ready, 1);
        check("rst_keys_valid", keys_valid, 0);
        check("rst_exp_err", exp_err, 0);
        check("rst_exp_start", exp_start, 0);
        check("rst_exp_key", exp_key, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        tick;

        // first key load and full expansion
        key_load = 1'b1;
        key_in   = K1;
        #1 check("idle_key_ready", key_ready, 1);
        tick;
        key_load = 1'b0;
        key_in   = '0;
        check("load_exp_start", exp_start, 1);
        check("load_exp_key", exp_key, K1);
        check("load_key_ready", key_ready, 0);
        check("load_keys_valid", keys_valid, 0);
        tick;
        check("start_one_cycle", exp_start, 0);
        for (int k = 0; k < 15; k++) begin
            exp_valid  = 1'b1;
            exp_subkey = pat(4'(k));
            if (k == 2) begin
                key_load = 1'b1;
                key_in   = K2;
            end else begin
                key_load = 1'b0;
            end
            if (k == 14) check("kv_before_last", keys_valid, 0);
            tick;
        end
        exp_valid = 1'b0;
        key_load  = 1'b0;
        check("kv_after_last", keys_valid, 1);
        check("ready_key_ready", key_ready, 1);
        check("load_in_expand_ignored", exp_key, K1);
        exp_valid  = 1'b1;
        exp_subkey = '1;
        tick;
        exp_valid = 1'b0;
        check("stray_valid_kv", keys_valid, 1);

        // single encrypt read of round 3
        enc_req   = 1'b1;
        enc_round = 4'd3;
        #1;
        check("enc_gnt", enc_gnt, 1);
        check("enc_only_dec_gnt", dec_gnt, 0);
        tick;
        enc_req = 1'b0;
        check("enc_rd_valid", rd_valid, 1);
        check("enc_rd_id", rd_id, 0);
        check("enc_rd_err", rd_err, 0);
        check("enc_rd_data", rd_data, {128'h0, pat(4'd3)});
        #1 check("enc_gnt_drop", enc_gnt, 0);
        tick;
        check("idle_rd_valid", rd_valid, 0);
        check("idle_rd_data", rd_data, 0);

        // decrypt read out of range
        dec_req   = 1'b1;
        dec_round = 4'd15;
        #1;
        check("oob_dec_gnt", dec_gnt, 1);
        check("oob_enc_gnt", enc_gnt, 0);
        tick;
        dec_req = 1'b0;
        check("oob_rd_valid", rd_valid, 1);
        check("oob_rd_id", rd_id, 1);
        check("oob_rd_err", rd_err, 1);
        check("oob_rd_data", rd_data, 0);
        tick;
        check("oob_rd_valid_drop", rd_valid, 0);
        check("oob_rd_err_drop", rd_err, 0);

        // both requesting: alternate enc, dec, enc, dec
        enc_req   = 1'b1;
        enc_round = 4'd0;
        dec_req   = 1'b1;
        dec_round = 4'd14;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("alt_enc_gnt", enc_gnt, (i % 2 == 0));
            check("alt_dec_gnt", dec_gnt, (i % 2 == 1));
            tick;
            check("alt_rd_valid", rd_valid, 1);
            check("alt_rd_id", rd_id, (i % 2 == 1));
            check("alt_rd_data", rd_data, {128'h0, (i % 2 == 1) ? pat(4'hE) : pat(4'h0)});
        end
        enc_req = 1'b0;
        dec_req = 1'b0;
        tick;
        check("alt_done_rd_valid", rd_valid, 0);

        // rekey in READY while encrypt holds its request
        key_load  = 1'b1;
        key_in    = K2;
        enc_req   = 1'b1;
        enc_round = 4'd3;
        #1;
        check("rekey_no_enc_gnt", enc_gnt, 0);
        check("rekey_no_dec_gnt", dec_gnt, 0);
        tick;
        key_load = 1'b0;
        check("rekey_keys_valid", keys_valid, 0);
        check("rekey_key_ready", key_ready, 0);
        check("rekey_rd_valid", rd_valid, 0);
        check("rekey_exp_start", exp_start, 1);
        n_gnt = 0;
        for (int k = 0; k < 15; k++) begin
            exp_valid  = 1'b1;
            exp_subkey = pat(4'(14 - k));
            #1;
            if (enc_gnt || dec_gnt) n_gnt++;
            tick;
        end
        exp_valid = 1'b0;
        check("rekey_grants_during_expand", n_gnt, 0);
        check("rekey_kv_back", keys_valid, 1);
        #1 check("rekey_enc_gnt", enc_gnt, 1);
        tick;
        enc_req = 1'b0;
        check("rekey_rd_valid_new", rd_valid, 1);
        check("rekey_rd_data_new", rd_data, {128'h0, pat(4'hB)});

        // expansion stalls after 5 subkeys -> timeout
        key_load = 1'b1;
        key_in   = K3;
        tick;
        key_load = 1'b0;
        check("tmo_err_cleared", exp_err, 0);
        n_cyc = 0;
        for (int j = 0; j < 100; j++) begin
            if (key_ready) break;
            n_cyc++;
            exp_valid  = (j < 5);
            exp_subkey = pat(4'(j));
            tick;
        end
        exp_valid = 1'b0;
        check("tmo_cycles", n_cyc, 32);
        check("tmo_exp_err", exp_err, 1);
        check("tmo_keys_valid", keys_valid, 0);
        check("tmo_key_ready", key_ready, 1);
        tick;
        check("tmo_err_sticky", exp_err, 1);
        enc_req = 1'b1;
        #1 check("tmo_idle_no_gnt", enc_gnt, 0);
        enc_req  = 1'b0;
        key_load = 1'b1;
        key_in   = K1;
        tick;
        key_load = 1'b0;
        check("reload_clears_err", exp_err, 0);
        check("reload_exp_key", exp_key, K1);

        // reset in the middle of EXPAND
        exp_valid  = 1'b1;
        exp_subkey = pat(4'd7);
        tick;
        tick;
        exp_valid = 1'b0;
        reset     = 1'b1;
        tick;
        check("midrst_key_ready", key_ready, 1);
        check("midrst_keys_valid", keys_valid, 0);
        check("midrst_exp_start", exp_start, 0);
        check("midrst_exp_key", exp_key, 0);
        check("midrst_exp_err", exp_err, 0);
        check("midrst_rd_valid", rd_valid, 0);
        reset = 1'b0;
        tick;

`ifdef KEY_ZEROIZE_EN
        key_load = 1'b1;
        key_in   = K2;
        tick;
        key_load = 1'b0;
        for (int k = 0; k < 15; k++) begin
            exp_valid  = 1'b1;
            exp_subkey = pat(4'(k + 1));
            tick;
        end
        exp_valid = 1'b0;
        check("zz_ready", keys_valid, 1);
        zeroize   = 1'b1;
        enc_req   = 1'b1;
        enc_round = 4'd3;
        #1 check("zz_no_gnt", enc_gnt, 0);
        tick;
        zeroize = 1'b0;
        enc_req = 1'b0;
        check("zz_keys_valid", keys_valid, 0);
        check("zz_exp_key", exp_key, 0);
        check("zz_rd_valid", rd_valid, 0);
        check("zz_store3", dut.r_store[3], 0);
        check("zz_store14", dut.r_store[14], 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
